data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 116 +++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory behind a valid/ready request port.
// Clears itself after reset, then serves one request at a time after WAIT_STATES idle cycles.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        rwbar,
   input  logic [15:0] mem_addr,
   input  logic [15:0] wr_data,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic        wr_done,
   output logic        addr_err,
   output logic        busy
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_ptr;
   logic [3:0]              wcnt;
   logic                    rw_q;
   logic [15:0]             addr_q;
   logic [15:0]             data_q;
   logic [15:0]             mem [0:DEPTH-1];

   logic                    in_range;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [15:0]             mem_wdata;

   assign req_ready = (state == IDLE) && !flush;
   assign busy      = (state != IDLE);
   assign in_range  = (addr_q >> ADDR_WIDTH) == '0;
   assign idx       = addr_q[ADDR_WIDTH-1:0];

   // Single write port shared by the clear sweep and committed writes; reset blocks both.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
      if (!reset) begin
         if (state == CLEAR) begin
            mem_we = 1'b1;
         end else if (state == RESP && !rw_q && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLEAR;
         clr_ptr  <= '0;
         wcnt     <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         rd_valid <= 1'b0;
         wr_done  <= 1'b0;
         addr_err <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= 1'b0;
         wr_done  <= 1'b0;
         addr_err <= 1'b0;
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == '1) state <= IDLE;
            end
            IDLE: begin
               if (req_valid && req_ready) begin
                  rw_q   <= rwbar;
                  addr_q <= mem_addr;
                  data_q <= wr_data;
                  wcnt   <= WAIT_LOAD;
                  state  <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (flush)             state <= IDLE;
               else if (wcnt == '0)   state <= RESP;
               else                   wcnt  <= wcnt - 1'b1;
            end
            RESP: begin
               addr_err <= !in_range;
               if (rw_q) begin
                  rd_valid <= 1'b1;
                  rd_data  <= in_range ? mem[idx] : '0;
               end else begin
                  wr_done  <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
